// File: rtl/stream_crossbar_router.sv
// stream_crossbar_router
//   NUM_IN x NUM_OUT AXI-Stream crossbar with equal-width channels. Each
//   output has a run-time source select that only changes on packet
//   boundaries, a 2-entry skid buffer and a delivered-beat counter. One
//   input may feed several outputs at once; such a beat is written into
//   every selecting buffer in the same cycle, or into none of them.
//
// Optional feature (macro ROUTE_DROP_UNSEL_EN):
//   When defined, an input that no output selects is always ready (except
//   in a commit cycle), its beats are discarded and counted on drop_cnt.
//   When undefined, such inputs stall and drop_cnt does not exist.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_sel    per-output source select, field k = [k*SEL_W +: SEL_W];
//              values >= NUM_IN mean disconnected
//   cfg_valid  config write request
//   cfg_ready  high when no config update is pending
//   s_t*       input streams, channel i = [i*DWIDTH +: DWIDTH]
//   m_t*       output streams, channel k = [k*DWIDTH +: DWIDTH]
//   beat_cnt   per-output delivered beat count, field k = [k*CNT_W +: CNT_W]
//   drop_cnt   (ROUTE_DROP_UNSEL_EN only) total discarded beats
module stream_crossbar_router #(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 8,
  parameter int DWIDTH  = 1536,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_OUT*SEL_W-1:0]   cfg_sel,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [NUM_IN*DWIDTH-1:0]   s_tdata,
  input  logic [NUM_IN-1:0]          s_tvalid,
  input  logic [NUM_IN-1:0]          s_tlast,
  output logic [NUM_IN-1:0]          s_tready,
  output logic [NUM_OUT*DWIDTH-1:0]  m_tdata,
  output logic [NUM_OUT-1:0]         m_tvalid,
  output logic [NUM_OUT-1:0]         m_tlast,
  input  logic [NUM_OUT-1:0]         m_tready,
  output logic [NUM_OUT*CNT_W-1:0]   beat_cnt
`ifdef ROUTE_DROP_UNSEL_EN
  ,
  output logic [CNT_W-1:0]           drop_cnt
`endif
);

  // Configuration state
  logic                     pending;
  logic [NUM_OUT*SEL_W-1:0] pending_sel;
  logic [SEL_W-1:0]         active_sel [NUM_OUT];
  logic [NUM_OUT-1:0]       in_pkt;
  logic                     commit;

  // Skid buffers
  logic [1:0]               count  [NUM_OUT];
  logic [NUM_OUT-1:0]       wr_ptr;
  logic [NUM_OUT-1:0]       rd_ptr;
  logic [DWIDTH-1:0]        mem_data [NUM_OUT][2];
  logic                     mem_last [NUM_OUT][2];
  logic [CNT_W-1:0]         cnt    [NUM_OUT];

  // Routing
  logic [NUM_OUT-1:0][NUM_IN-1:0] sel_hit;
  logic [NUM_OUT-1:0]       space;
  logic [NUM_IN-1:0]        used;
  logic [NUM_IN-1:0]        blocked;
  logic [NUM_OUT-1:0]       push;
  logic [NUM_OUT-1:0]       pop;
  logic [DWIDTH-1:0]        push_data [NUM_OUT];
  logic [NUM_OUT-1:0]       push_last;

  // A config update may only take effect when no output is mid-packet.
  assign commit    = pending && (in_pkt == '0);
  assign cfg_ready = !pending;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_hit = '0;
    used    = '0;
    blocked = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      space[k] = (count[k] != 2'd2);
      // Out-of-range selects match no input and so read as disconnected.
      for (int i = 0; i < NUM_IN; i++) begin
        sel_hit[k][i] = (active_sel[k] == SEL_W'(i));
        if (sel_hit[k][i]) begin
          used[i] = 1'b1;
          if (count[k] == 2'd2) blocked[i] = 1'b1;
        end
      end
    end
    // AND-fork: an input is ready only when every selecting buffer has room.
    for (int i = 0; i < NUM_IN; i++) begin
`ifdef ROUTE_DROP_UNSEL_EN
      s_tready[i] = !rst && !commit && !blocked[i];
`else
      s_tready[i] = !rst && !commit && used[i] && !blocked[i];
`endif
    end
  end

  always_comb begin
    push      = '0;
    push_last = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      push_data[k] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_hit[k][i]) begin
          push[k]      = s_tvalid[i] && s_tready[i];
          push_data[k] = s_tdata[i*DWIDTH +: DWIDTH];
          push_last[k] = s_tlast[i];
        end
      end
    end
  end

  // Outputs are forced to zero while empty, so data reads 0 after reset
  // without clearing the storage itself.
  always_comb begin
    m_tdata  = '0;
    m_tlast  = '0;
    m_tvalid = '0;
    beat_cnt = '0;
    pop      = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      m_tvalid[k] = (count[k] != 2'd0);
      pop[k]      = m_tvalid[k] && m_tready[k];
      if (m_tvalid[k]) begin
        m_tdata[k*DWIDTH +: DWIDTH] = mem_data[k][rd_ptr[k]];
        m_tlast[k]                  = mem_last[k][rd_ptr[k]];
      end
      beat_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      pending_sel <= '0;
      in_pkt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        active_sel[k] <= SEL_W'(NUM_IN);
        count[k]      <= 2'd0;
        cnt[k]        <= '0;
      end
    end else begin
      // cfg_ready and commit are mutually exclusive (both depend on pending).
      if (cfg_valid && cfg_ready) begin
        pending     <= 1'b1;
        pending_sel <= cfg_sel;
      end else if (commit) begin
        pending <= 1'b0;
        for (int k = 0; k < NUM_OUT; k++)
          active_sel[k] <= pending_sel[k*SEL_W +: SEL_W];
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= ~wr_ptr[k];
          in_pkt[k] <= !push_last[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
          cnt[k]    <= cnt[k] + 1'b1;
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 2'd1;
          2'b01:   count[k] <= count[k] - 2'd1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; the occupancy count is
  // what marks entries valid, and a wide reset here would be pure cost.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (push[k]) begin
        mem_data[k][wr_ptr[k]] <= push_data[k];
        mem_last[k][wr_ptr[k]] <= push_last[k];
      end
    end
  end

`ifdef ROUTE_DROP_UNSEL_EN
  logic [CNT_W-1:0] drop_inc;

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (s_tvalid[i] && s_tready[i] && !used[i]) drop_inc = drop_inc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_cnt + drop_inc;
  end
`endif

endmodule

// File: tb/tb_stream_crossbar_router.sv
// Self-checking bench for stream_crossbar_router. Source queues feed the
// inputs; accepted beats are pushed into per-output expected queues and
// popped as the outputs deliver them.
module tb_stream_crossbar_router;
  localparam int NUM_IN  = 5;
  localparam int NUM_OUT = 8;
  localparam int DWIDTH  = 1536;
  localparam int SEL_W   = 4;
  localparam int CNT_W   = 32;
`ifdef ROUTE_DROP_UNSEL_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] w;
    logic        last;
  } beat_t;

  logic                      clk;
  logic                      rst;
  logic [NUM_OUT*SEL_W-1:0]  cfg_sel;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NUM_IN*DWIDTH-1:0]  s_tdata;
  logic [NUM_IN-1:0]         s_tvalid;
  logic [NUM_IN-1:0]         s_tlast;
  logic [NUM_IN-1:0]         s_tready;
  logic [NUM_OUT*DWIDTH-1:0] m_tdata;
  logic [NUM_OUT-1:0]        m_tvalid;
  logic [NUM_OUT-1:0]        m_tlast;
  logic [NUM_OUT-1:0]        m_tready;
  logic [NUM_OUT*CNT_W-1:0]  beat_cnt;
`ifdef ROUTE_DROP_UNSEL_EN
  logic [CNT_W-1:0]          drop_cnt;
`endif

  stream_crossbar_router #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DWIDTH(DWIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_sel(cfg_sel), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .beat_cnt(beat_cnt)
`ifdef ROUTE_DROP_UNSEL_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each 32-bit lane differs so lane/slice errors show up in the full compare.
  function automatic logic [DWIDTH-1:0] mk_data(input logic [31:0] w);
    logic [DWIDTH-1:0] d;
    for (int j = 0; j < DWIDTH/32; j++) d[j*32 +: 32] = w ^ (32'(j) * 32'h0100_0193);
    return d;
  endfunction

  // Stimulus and reference model state
  beat_t            src_q [NUM_IN][$];
  beat_t            exp_q [NUM_OUT][$];
  logic [SEL_W-1:0] m_sel [NUM_OUT];
  logic             m_pending;
  logic [31:0]      m_pending_sel;
  logic [NUM_OUT-1:0] m_in_pkt;
  logic [CNT_W-1:0] m_cnt [NUM_OUT];
  logic [CNT_W-1:0] m_drop;
  int               acc [NUM_IN];
  int               n_commit;
  logic             mon_commit;
  logic [NUM_IN-1:0] mon_used, mon_blocked;
  logic             mon_diff;
  beat_t            mon_b;

  function automatic bit drained();
    for (int i = 0; i < NUM_IN; i++)  if (src_q[i].size() != 0) return 1'b0;
    for (int k = 0; k < NUM_OUT; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Source driver: presents the head of each source queue.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = src_q[i][0].last;
        s_tdata[i*DWIDTH +: DWIDTH] = mk_data(src_q[i][0].w);
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  end

  // Monitor: checks every output against the model mid-cycle, then advances
  // the model by the handshakes that the coming rising edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        exp_q[k].delete();
        m_sel[k] = SEL_W'(NUM_IN);
        m_cnt[k] = '0;
      end
      m_pending = 1'b0;
      m_in_pkt  = '0;
      m_drop    = '0;
    end else begin
      mon_commit  = m_pending && (m_in_pkt == '0);
      mon_used    = '0;
      mon_blocked = '0;
      for (int k = 0; k < NUM_OUT; k++)
        for (int i = 0; i < NUM_IN; i++)
          if (m_sel[k] == SEL_W'(i)) begin
            mon_used[i] = 1'b1;
            if (exp_q[k].size() >= 2) mon_blocked[i] = 1'b1;
          end
      for (int i = 0; i < NUM_IN; i++)
        check($sformatf("s_tready[%0d]", i), 64'(s_tready[i]),
              64'(!mon_commit && !mon_blocked[i] && (mon_used[i] || DROP_EN)));
      check("cfg_ready", 64'(cfg_ready), 64'(!m_pending));
`ifdef ROUTE_DROP_UNSEL_EN
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
      for (int k = 0; k < NUM_OUT; k++) begin
        check($sformatf("beat_cnt[%0d]", k), 64'(beat_cnt[k*CNT_W +: CNT_W]), 64'(m_cnt[k]));
        check($sformatf("m_tvalid[%0d]", k), 64'(m_tvalid[k]), 64'(exp_q[k].size() > 0));
        if (exp_q[k].size() > 0) begin
          mon_b    = exp_q[k][0];
          mon_diff = (m_tdata[k*DWIDTH +: DWIDTH] != mk_data(mon_b.w));
          check($sformatf("m_beat[%0d]", k),
                {m_tdata[k*DWIDTH +: 32], 30'd0, mon_diff, m_tlast[k]},
                {mon_b.w, 30'd0, 1'b0, mon_b.last});
          if (m_tvalid[k] && m_tready[k]) begin
            void'(exp_q[k].pop_front());
            m_cnt[k] = m_cnt[k] + 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (s_tvalid[i] && s_tready[i] && src_q[i].size() > 0) begin
          mon_b = src_q[i].pop_front();
          acc[i]++;
          if (!mon_used[i]) m_drop = m_drop + 1'b1;
          for (int k = 0; k < NUM_OUT; k++)
            if (m_sel[k] == SEL_W'(i)) begin
              exp_q[k].push_back(mon_b);
              m_in_pkt[k] = !mon_b.last;
            end
        end
      end
      if (mon_commit) begin
        n_commit++;
        m_pending = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) m_sel[k] = m_pending_sel[k*SEL_W +: SEL_W];
      end else if (cfg_valid && !m_pending) begin
        m_pending     = 1'b1;
        m_pending_sel = cfg_sel;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input int i, input logic [31:0] base, input int len);
    for (int j = 0; j < len; j++) src_q[i].push_back('{w: base + 32'(j), last: (j == len - 1)});
  endtask

  task automatic wait_cfg_done();
    int n = 0;
    while (!cfg_ready && n < 200) begin tick(); n++; end
    check("cfg_commit_timeout", 64'(cfg_ready), 64'd1);
  endtask

  task automatic do_cfg(input logic [31:0] v);
    wait_cfg_done();
    cfg_sel   = v;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    wait_cfg_done();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin tick(); n++; end
    check("drain_timeout", 64'(drained()), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nc0, n;
    logic [CNT_W-1:0] drop0;
    n_tests = 0; n_fail = 0; n_commit = 0;
    for (int i = 0; i < NUM_IN; i++) acc[i] = 0;
    rst = 1'b1; cfg_sel = '1; cfg_valid = 1'b0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = '1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_beat_cnt_nz", 64'(beat_cnt != '0), 64'd0);
    check("rst_tdata_nz", 64'(m_tdata != '0), 64'd0);

    // Single route: out0 <- in2 (field 7 = 5, out of range = disconnected)
    do_cfg(32'h5FFF_FFF2);
    push_pkt(2, 32'h11, 4);
    wait_drain(50);
    check("t1_beat_cnt0", 64'(beat_cnt[CNT_W-1:0]), 64'd4);

    // Broadcast: out1 = out3 = in0, out3 stalled for 5 cycles
    do_cfg(32'hFFFF_0F02);
    m_tready = 8'hF7;
    base = acc[0];
    push_pkt(0, 32'h100, 6);
    repeat (5) tick();
    check("t2_accepted", 64'(acc[0] - base), 64'd2);
    check("t2_s_tready0", 64'(s_tready[0]), 64'd0);
    m_tready = '1;
    wait_drain(50);

    // Packet-boundary switch: out0 from in2 to in1 mid-packet
    nc0  = n_commit;
    base = acc[2];
    push_pkt(2, 32'h21, 8);
    if (!DROP_EN) push_pkt(1, 32'h31, 3);
    n = 0;
    while (acc[2] < base + 2 && n < 50) begin tick(); n++; end
    check("t3_start_timeout", 64'(acc[2] >= base + 2), 64'd1);
    cfg_sel   = 32'hFFFF_0F01;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    wait_cfg_done();
    check("t3_in2_done", 64'(acc[2] - base), 64'd8);
    check("t3_one_commit", 64'(n_commit - nc0), 64'd1);
    if (DROP_EN) push_pkt(1, 32'h31, 3);
    wait_drain(100);

    // Backpressure: m_tready[0] toggles during a 16-beat burst
    push_pkt(1, 32'h41, 16);
    n = 0;
    while (!drained() && n < 100) begin
      m_tready[0] = ~m_tready[0];
      tick();
      n++;
    end
    m_tready[0] = 1'b1;
    wait_drain(50);

    // Asynchronous reset mid-packet
    push_pkt(1, 32'h51, 8);
    repeat (3) tick();
    check("t5_pre_valid", 64'(m_tvalid[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_rst_beat_cnt_nz", 64'(beat_cnt != '0), 64'd0);
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    repeat (2) tick();
    rst = 1'b0;
    check("t5_cfg_ready", 64'(cfg_ready), 64'd1);
    push_pkt(1, 32'h61, 2);
    repeat (5) tick();
    check("t5_disconnected", 64'(src_q[1].size()), DROP_EN ? 64'd0 : 64'd2);
    src_q[1].delete();
    tick();

    // Unselected input 4
`ifdef ROUTE_DROP_UNSEL_EN
    drop0 = drop_cnt;
`else
    drop0 = '0;
`endif
    push_pkt(4, 32'h71, 10);
    repeat (15) tick();
`ifdef ROUTE_DROP_UNSEL_EN
    check("t6_s_tready4", 64'(s_tready[4]), 64'd1);
    check("t6_drop_cnt", 64'(drop_cnt - drop0), 64'd10);
    check("t6_src_left", 64'(src_q[4].size()), 64'd0);
`else
    check("t6_s_tready4", 64'(s_tready[4]), 64'd0);
    check("t6_src_left", 64'(src_q[4].size()), 64'(10 + drop0));
`endif
    src_q[4].delete();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
